// File: rtl/alu_nibble_sequencer.sv
// Command-side master for a 4-bit ALU: splits wide ADD/SUB/logic commands into
// per-nibble ALU operations (LSB first) and reassembles the wide response.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_A,
    input  logic [W-1:0] cmd_B,
    output logic [2:0]   alu_op_sel,
    output logic [3:0]   alu_A,
    output logic [3:0]   alu_B,
    input  logic [3:0]   alu_Result,
    input  logic         alu_CarryOut,
    input  logic         alu_ZeroFlag,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_Result,
    output logic         rsp_CarryOut,
    output logic         rsp_ZeroFlag,
    output logic         rsp_Error
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    op_reg, op_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic [W-1:0]  res_reg, res_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [3:0]    tmp_reg, tmp_next;
    logic          cin_reg, cin_next;
    logic          c1_reg, c1_next;
    logic          zacc_reg, zacc_next;
    logic          err_reg, err_next;

    logic [3:0]    a_nibs [NIBBLES];
    logic [3:0]    b_nibs [NIBBLES];
    logic [W-1:0]  res_wr;
    logic          is_arith;

    // res_wr is res_reg with the current nibble replaced by the ALU result
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[gi*4 +: 4];
            assign b_nibs[gi] = b_reg[gi*4 +: 4];
            assign res_wr[gi*4 +: 4] = (idx_reg == IW'(gi)) ? alu_Result : res_reg[gi*4 +: 4];
        end
    endgenerate

    assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_AND;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            idx_reg   <= '0;
            tmp_reg   <= '0;
            cin_reg   <= 1'b0;
            c1_reg    <= 1'b0;
            zacc_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            idx_reg   <= idx_next;
            tmp_reg   <= tmp_next;
            cin_reg   <= cin_next;
            c1_reg    <= c1_next;
            zacc_reg  <= zacc_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        idx_next   = idx_reg;
        tmp_next   = tmp_reg;
        cin_next   = cin_reg;
        c1_next    = c1_reg;
        zacc_next  = zacc_reg;
        err_next   = err_reg;
        alu_op_sel = OP_AND;
        alu_A      = 4'h0;
        alu_B      = 4'h0;
        cmd_ready  = (state_reg == IDLE) && !rst;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_next  = cmd_op;
                    a_next   = cmd_A;
                    b_next   = cmd_B;
                    res_next = '0;
                    idx_next = '0;
                    cin_next = 1'b0;
                    c1_next  = 1'b0;
                    if (cmd_op[2:1] == 2'b11) begin
                        err_next   = 1'b1;
                        zacc_next  = 1'b0;
                        state_next = RESP;
                    end else begin
                        err_next   = 1'b0;
                        zacc_next  = 1'b1;
                        state_next = PASS1;
                    end
                end
            end
            PASS1: begin
                alu_op_sel = op_reg;
                alu_A      = a_nibs[idx_reg];
                alu_B      = b_nibs[idx_reg];
                if (is_arith && cin_reg) begin
                    // Incoming carry/borrow is applied in a second ALU pass
                    tmp_next   = alu_Result;
                    c1_next    = alu_CarryOut;
                    state_next = PASS2;
                end else begin
                    res_next   = res_wr;
                    zacc_next  = zacc_reg & alu_ZeroFlag;
                    cin_next   = is_arith ? alu_CarryOut : 1'b0;
                    idx_next   = (idx_reg == LAST_IDX) ? idx_reg : idx_reg + 1'b1;
                    state_next = (idx_reg == LAST_IDX) ? RESP : PASS1;
                end
            end
            PASS2: begin
                alu_op_sel = op_reg;
                alu_A      = tmp_reg;
                alu_B      = 4'b0001;
                res_next   = res_wr;
                zacc_next  = zacc_reg & alu_ZeroFlag;
                cin_next   = c1_reg | alu_CarryOut;
                idx_next   = (idx_reg == LAST_IDX) ? idx_reg : idx_reg + 1'b1;
                state_next = (idx_reg == LAST_IDX) ? RESP : PASS1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid    = (state_reg == RESP);
    assign rsp_Result   = res_reg;
    assign rsp_CarryOut = cin_reg;
    assign rsp_ZeroFlag = zacc_reg;
    assign rsp_Error    = err_reg;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES=4) with a behavioural 4-bit ALU on the
// ALU side; directed vector table plus hold/reset sequences.
module tb_alu_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_A, cmd_B;
    logic [2:0]  alu_op_sel;
    logic [3:0]  alu_A, alu_B;
    logic [3:0]  alu_Result;
    logic        alu_CarryOut, alu_ZeroFlag;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_Result;
    logic        rsp_CarryOut, rsp_ZeroFlag, rsp_Error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_A(cmd_A), .cmd_B(cmd_B),
        .alu_op_sel(alu_op_sel), .alu_A(alu_A), .alu_B(alu_B),
        .alu_Result(alu_Result), .alu_CarryOut(alu_CarryOut), .alu_ZeroFlag(alu_ZeroFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_Result(rsp_Result),
        .rsp_CarryOut(rsp_CarryOut), .rsp_ZeroFlag(rsp_ZeroFlag), .rsp_Error(rsp_Error)
    );

    // 4-bit ALU model
    always_comb begin
        logic [4:0] sum;
        sum          = 5'd0;
        alu_Result   = 4'h0;
        alu_CarryOut = 1'b0;
        case (alu_op_sel)
            3'b000: begin sum = {1'b0, alu_A} + {1'b0, alu_B}; alu_Result = sum[3:0]; alu_CarryOut = sum[4]; end
            3'b001: begin alu_Result = alu_A - alu_B; alu_CarryOut = (alu_A < alu_B); end
            3'b010: alu_Result = alu_A & alu_B;
            3'b011: alu_Result = alu_A | alu_B;
            3'b100: alu_Result = alu_A ^ alu_B;
            3'b101: alu_Result = ~alu_A;
            default: alu_Result = 4'h0;
        endcase
        alu_ZeroFlag = (alu_Result == 4'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command; lat counts clock edges after the accept edge until rsp_valid.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input bit release_rsp,
                           output logic [15:0] r, output logic c, output logic z,
                           output logic e, output int lat);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_A = a; cmd_B = b;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
        r = rsp_Result; c = rsp_CarryOut; z = rsp_ZeroFlag; e = rsp_Error;
        if (release_rsp) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a, b, res;
        logic        carry, zero, err;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [15:0] r, r0;
        logic        c, z, e, c0, z0, e0;
        int          lat;

        vecs[0] = '{"add_00ff_1",  3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 6};
        vecs[1] = '{"add_ffff_1",  3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 7};
        vecs[2] = '{"sub_0_1",     3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 7};
        vecs[3] = '{"sub_eq",      3'b001, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 4};
        vecs[4] = '{"xor",         3'b100, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4};
        vecs[5] = '{"not",         3'b101, 16'h0F0F, 16'hFFFF, 16'hF0F0, 1'b0, 1'b0, 1'b0, 4};
        vecs[6] = '{"and",         3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 4};
        vecs[7] = '{"or",          3'b011, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 4};
        vecs[8] = '{"add_nocarry", 3'b000, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 4};
        vecs[9] = '{"illegal_111", 3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_A = '0; cmd_B = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_all", {12'd0, rsp_Result, rsp_CarryOut, rsp_ZeroFlag, rsp_Error, 1'b0}, 32'd0);
        check("idle_alu_drive", {21'd0, alu_op_sel, alu_A, alu_B}, {21'd0, 3'b010, 8'h00});
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, r, c, z, e, lat);
            $display("[TB] %s op=%b A=%h B=%h -> R=%h C=%b Z=%b E=%b lat=%0d",
                     vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, r, c, z, e, lat);
            check({vecs[i].name, "_result"}, {16'd0, r}, {16'd0, vecs[i].res});
            check({vecs[i].name, "_carry"}, {31'd0, c}, {31'd0, vecs[i].carry});
            check({vecs[i].name, "_zero"}, {31'd0, z}, {31'd0, vecs[i].zero});
            check({vecs[i].name, "_error"}, {31'd0, e}, {31'd0, vecs[i].err});
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
        end

        // Illegal op 110 with the response held off for 5 cycles
        run_cmd(3'b110, 16'hBEEF, 16'h0001, 1'b0, r0, c0, z0, e0, lat);
        $display("[TB] illegal_110_hold R=%h C=%b Z=%b E=%b lat=%0d", r0, c0, z0, e0, lat);
        check("illegal_110_error", {31'd0, e0}, 32'd1);
        check("illegal_110_latency", lat, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_fields", {12'd0, rsp_Result, rsp_CarryOut, rsp_ZeroFlag, rsp_Error, 1'b0},
                  {12'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_handshake_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_handshake_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset while PASS1 of nibble 2 is in progress
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_A = 16'h1111; cmd_B = 16'h2222;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midop_partial_result", {16'd0, rsp_Result}, 32'h0033);
        rst = 1'b1;
        @(posedge clk); #1;
        $display("[TB] midop_reset R=%h C=%b Z=%b E=%b V=%b", rsp_Result, rsp_CarryOut,
                 rsp_ZeroFlag, rsp_Error, rsp_valid);
        check("midop_reset_rsp", {12'd0, rsp_Result, rsp_CarryOut, rsp_ZeroFlag, rsp_Error, rsp_valid}, 32'd0);
        check("midop_reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("midop_reset_alu_idle", {21'd0, alu_op_sel, alu_A, alu_B}, {21'd0, 3'b010, 8'h00});
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
        end
        run_cmd(3'b000, 16'h0003, 16'h0004, 1'b1, r, c, z, e, lat);
        $display("[TB] add_3_4_after_reset R=%h C=%b Z=%b E=%b lat=%0d", r, c, z, e, lat);
        check("add_3_4_result", {16'd0, r}, 32'h0007);
        check("add_3_4_flags", {29'd0, c, z, e}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
